bus_dest_regs: RTL and testbench

Destination side of the core's internal bus. Each cycle it latches the shared bus word into any set of the core's working registers (AR, R, IR, RL, RC, RP, RQ, R1, AC) selected by the control unit's write-enable vector. It also provides increment counters on AR/RC/RP/RQ, ALU write-back into AC, and a registered zero flag. It sits between the bus source multiplexer output and the ALU/control unit, and its register outputs feed back into that multiplexer and the ALU.

---
 rtl/bus_dest_regs.sv | 80 ++++++++
 tb/tb_bus_dest_regs.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bus_dest_regs.sv
// Destination side of the internal bus: working registers with bus load,
// increment counters, ALU write-back into AC and a registered zero flag.
module bus_dest_regs #(
  parameter int WIDTH    = 12,
  parameter int IR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [WIDTH-1:0]    busIn,
  input  logic [8:0]          writeEn,
  input  logic [3:0]          incEn,
  input  logic [WIDTH-1:0]    aluOut,
  input  logic                aluWrEn,
  output logic [WIDTH-1:0]    AR,
  output logic [WIDTH-1:0]    R,
  output logic [IR_WIDTH-1:0] IR,
  output logic [WIDTH-1:0]    RL,
  output logic [WIDTH-1:0]    RC,
  output logic [WIDTH-1:0]    RP,
  output logic [WIDTH-1:0]    RQ,
  output logic [WIDTH-1:0]    R1,
  output logic [WIDTH-1:0]    AC,
  output logic                zFlag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] ac_next;
  logic             ac_wr;

  // ALU write-back outranks a bus load into AC
  always_comb begin
    ac_wr   = aluWrEn | writeEn[8];
    ac_next = aluWrEn ? aluOut : busIn;
  end

  // Counter registers: a bus load drops a same-cycle increment
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      AR <= '0;
      RC <= '0;
      RP <= '0;
      RQ <= '0;
    end else begin
      if (writeEn[0])     AR <= busIn;
      else if (incEn[0])  AR <= AR + ONE;
      if (writeEn[4])     RC <= busIn;
      else if (incEn[1])  RC <= RC + ONE;
      if (writeEn[5])     RP <= busIn;
      else if (incEn[2])  RP <= RP + ONE;
      if (writeEn[6])     RQ <= busIn;
      else if (incEn[3])  RQ <= RQ + ONE;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      R  <= '0;
      IR <= '0;
      RL <= '0;
      R1 <= '0;
    end else begin
      if (writeEn[1]) R  <= busIn;
      if (writeEn[2]) IR <= busIn[IR_WIDTH-1:0];
      if (writeEn[3]) RL <= busIn;
      if (writeEn[7]) R1 <= busIn;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      AC    <= '0;
      zFlag <= 1'b0;
    end else if (ac_wr) begin
      AC    <= ac_next;
      zFlag <= (ac_next == '0);
    end
  end

endmodule

// File: tb/tb_bus_dest_regs.sv
// Scoreboard bench for bus_dest_regs: expected register images are queued
// at drive time and popped after each active edge.
module tb_bus_dest_regs;

  logic        clk = 1'b0;
  logic        rstN;
  logic [11:0] busIn;
  logic [8:0]  writeEn;
  logic [3:0]  incEn;
  logic [11:0] aluOut;
  logic        aluWrEn;
  logic [11:0] AR, R, RL, RC, RP, RQ, R1, AC;
  logic [7:0]  IR;
  logic        zFlag;

  typedef struct {
    logic [11:0] ar, r, rl, rc, rp, rq, r1, ac;
    logic [7:0]  ir;
    logic        z;
  } regs_t;

  regs_t m;
  regs_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  bus_dest_regs dut (
    .clk(clk), .rstN(rstN), .busIn(busIn), .writeEn(writeEn),
    .incEn(incEn), .aluOut(aluOut), .aluWrEn(aluWrEn),
    .AR(AR), .R(R), .IR(IR), .RL(RL), .RC(RC), .RP(RP),
    .RQ(RQ), .R1(R1), .AC(AC), .zFlag(zFlag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic regs_t clr();
    regs_t z;
    z.ar = 0; z.r = 0; z.rl = 0; z.rc = 0; z.rp = 0;
    z.rq = 0; z.r1 = 0; z.ac = 0; z.ir = 0; z.z = 0;
    return z;
  endfunction

  function automatic logic [11:0] upd(input logic [11:0] cur,
      input logic ld, input logic inc, input logic [11:0] bus);
    if (ld) return bus;
    if (inc) return cur + 12'd1;
    return cur;
  endfunction

  function automatic regs_t model(input regs_t s, input logic [8:0] we,
      input logic [3:0] inc, input logic [11:0] bus,
      input logic [11:0] alu, input logic awe);
    regs_t n = s;
    n.ar = upd(s.ar, we[0], inc[0], bus);
    n.rc = upd(s.rc, we[4], inc[1], bus);
    n.rp = upd(s.rp, we[5], inc[2], bus);
    n.rq = upd(s.rq, we[6], inc[3], bus);
    n.r  = upd(s.r,  we[1], 1'b0, bus);
    n.rl = upd(s.rl, we[3], 1'b0, bus);
    n.r1 = upd(s.r1, we[7], 1'b0, bus);
    if (we[2]) n.ir = bus[7:0];
    if (awe) begin
      n.ac = alu; n.z = (alu == 12'd0);
    end else if (we[8]) begin
      n.ac = bus; n.z = (bus == 12'd0);
    end
    return n;
  endfunction

  task automatic cmp_all(input string p, input regs_t e);
    chk({p, ".AR"}, {4'h0, AR}, {4'h0, e.ar});
    chk({p, ".R"},  {4'h0, R},  {4'h0, e.r});
    chk({p, ".IR"}, {8'h0, IR}, {8'h0, e.ir});
    chk({p, ".RL"}, {4'h0, RL}, {4'h0, e.rl});
    chk({p, ".RC"}, {4'h0, RC}, {4'h0, e.rc});
    chk({p, ".RP"}, {4'h0, RP}, {4'h0, e.rp});
    chk({p, ".RQ"}, {4'h0, RQ}, {4'h0, e.rq});
    chk({p, ".R1"}, {4'h0, R1}, {4'h0, e.r1});
    chk({p, ".AC"}, {4'h0, AC}, {4'h0, e.ac});
    chk({p, ".Z"},  {15'h0, zFlag}, {15'h0, e.z});
  endtask

  task automatic cycle(input string p, input logic [8:0] we,
      input logic [3:0] inc, input logic [11:0] bus,
      input logic [11:0] alu = 12'h0, input logic awe = 1'b0);
    regs_t e;
    @(negedge clk);
    writeEn = we; incEn = inc; busIn = bus;
    aluOut = alu; aluWrEn = awe;
    m = model(m, we, inc, bus, alu, awe);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk({p, ".q_empty"}, 16'd0, 16'd1);
    else begin
      e = exp_q.pop_front();
      cmp_all(p, e);
    end
  endtask

  initial begin
    rstN = 1'b0; busIn = 0; writeEn = 0; incEn = 0;
    aluOut = 0; aluWrEn = 0;
    m = clr();
    #12;
    cmp_all("por", clr());
    @(negedge clk) rstN = 1'b1;

    cycle("pre", 9'h1FF, 4'h0, 12'h123);

    // reset asserted mid-cycle while every load is enabled
    @(negedge clk);
    writeEn = 9'h1FF; busIn = 12'hABC;
    #2 rstN = 1'b0;
    #1;
    m = clr();
    cmp_all("rst", m);
    @(negedge clk) rstN = 1'b1;
    cycle("rel", 9'h1FF, 4'h0, 12'hABC);
    chk("rel.IR_bc", {8'h0, IR}, 16'h00BC);
    chk("rel.RQ_abc", {4'h0, RQ}, 16'h0ABC);

    cycle("bcast", 9'h084, 4'h0, 12'hF5A);
    chk("bcast.IR", {8'h0, IR}, 16'h005A);
    chk("bcast.R1", {4'h0, R1}, 16'h0F5A);
    chk("bcast.R", {4'h0, R}, 16'h0ABC);

    cycle("ldrp", 9'h020, 4'h0, 12'hFFE);
    cycle("inc1", 9'h000, 4'b0100, 12'h000);
    chk("wrap.fff", {4'h0, RP}, 16'h0FFF);
    cycle("inc2", 9'h000, 4'b0100, 12'h000);
    chk("wrap.000", {4'h0, RP}, 16'h0000);
    cycle("prio", 9'h020, 4'b0100, 12'h010);
    chk("prio.RP", {4'h0, RP}, 16'h0010);

    cycle("alu", 9'h100, 4'h0, 12'h007, 12'h000, 1'b1);
    chk("alu.AC", {4'h0, AC}, 16'h0000);
    chk("alu.Z", {15'h0, zFlag}, 16'h0001);
    cycle("busac", 9'h100, 4'h0, 12'h007);
    chk("busac.AC", {4'h0, AC}, 16'h0007);
    chk("busac.Z", {15'h0, zFlag}, 16'h0000);
    cycle("idle", 9'h000, 4'h0, 12'h000);
    chk("idle.Z", {15'h0, zFlag}, 16'h0000);

    cycle("ldar", 9'h001, 4'h0, 12'h0FF);
    cycle("ldrc", 9'h010, 4'h0, 12'h000);
    for (int i = 0; i < 3; i++) cycle("par", 9'h000, 4'b0011, 12'h000);
    chk("par.AR", {4'h0, AR}, 16'h0102);
    chk("par.RC", {4'h0, RC}, 16'h0003);
    chk("par.RP", {4'h0, RP}, 16'h0010);
    chk("par.RQ", {4'h0, RQ}, 16'h0ABC);

    // register-to-register move through the bus
    cycle("mv", 9'h100, 4'h0, R);
    chk("mv.AC", {4'h0, AC}, 16'h0ABC);

    for (int i = 0; i < 60; i++) begin
      logic [11:0] b;
      b = (i % 7 == 0) ? 12'h000 : 12'($urandom);
      cycle("rnd", 9'($urandom), 4'($urandom), b,
            (i % 5 == 0) ? 12'h000 : 12'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
